// File: rtl/window_fetch_unit.sv
// Reads a k x k window per lane from an internal image memory in row-major order,
// zero-padding out-of-image elements, behind a valid/ready output handshake.
module window_fetch_unit #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int NUM_UNITS    = 2,
  parameter int MAX_KERNEL   = 4,
  localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  localparam int RW = $clog2(IMAGE_HEIGHT),
  localparam int CW = $clog2(IMAGE_WIDTH),
  localparam int KW = $clog2(MAX_KERNEL + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_wr_en,
  input  logic [AW-1:0]                   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]           i_wr_data,
  input  logic                            i_start,
  input  logic [NUM_UNITS*RW-1:0]         i_start_row,
  input  logic [NUM_UNITS*CW-1:0]         i_start_col,
  input  logic [KW-1:0]                   i_kernel_dim,
  output logic [NUM_UNITS*DATA_WIDTH-1:0] o_out,
  output logic [NUM_UNITS-1:0]            o_out_pad,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int AW1 = AW + 1;
  localparam logic [AW1-1:0] IMG_W = AW1'(IMAGE_WIDTH);
  localparam logic [AW1-1:0] IMG_H = AW1'(IMAGE_HEIGHT);
  localparam logic [KW-1:0]  K_MAX = KW'(MAX_KERNEL);
  localparam logic [KW-1:0]  K_ONE = KW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t r_state, w_state_next;
  logic [KW-1:0] r_k, r_row_off, r_col_off;
  logic [KW-1:0] w_ld_row, w_ld_col;
  logic          r_valid;
  logic          w_k_ok, w_start_ok, w_row_end, w_last, w_adv, w_load;

  logic [DATA_WIDTH-1:0] r_mem [IMAGE_WIDTH*IMAGE_HEIGHT];

  // Lane reads sample r_mem in their own blocks, so a same-edge write is seen as old data.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign w_k_ok     = (i_kernel_dim != '0) && (i_kernel_dim <= K_MAX);
  assign w_start_ok = (r_state == S_IDLE) && i_start && w_k_ok;
  assign w_row_end  = (r_col_off == r_k - K_ONE);
  assign w_last     = w_row_end && (r_row_off == r_k - K_ONE);
  assign w_adv      = r_valid && i_out_ready;
  assign w_load     = (r_state == S_FETCH) && (!r_valid || (w_adv && !w_last));

  // Offsets of the element to load: (0,0) on the first load, else the successor.
  always_comb begin
    w_ld_row = r_row_off;
    w_ld_col = r_col_off;
    if (r_valid) begin
      if (w_row_end) begin
        w_ld_row = r_row_off + K_ONE;
        w_ld_col = '0;
      end else begin
        w_ld_col = r_col_off + K_ONE;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = w_k_ok ? S_FETCH : S_DONE;
      S_FETCH: if (w_adv && w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_k       <= '0;
      r_row_off <= '0;
      r_col_off <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_ok) begin
        r_k       <= i_kernel_dim;
        r_row_off <= '0;
        r_col_off <= '0;
      end
      if (w_load) begin
        r_row_off <= w_ld_row;
        r_col_off <= w_ld_col;
        r_valid   <= 1'b1;
      end else if (w_adv && w_last) begin
        r_valid <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      logic [RW-1:0]         r_org_row;
      logic [CW-1:0]         r_org_col;
      logic                  r_pad;
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic [AW1-1:0]        w_abs_row, w_abs_col;
      logic [AW-1:0]         w_rd_addr;
      logic                  w_pad;

      assign w_abs_row = AW1'(r_org_row) + AW1'(w_ld_row);
      assign w_abs_col = AW1'(r_org_col) + AW1'(w_ld_col);
      assign w_pad     = (w_abs_row >= IMG_H) || (w_abs_col >= IMG_W);
      // Only used when not padding, so the truncated address is always in range.
      assign w_rd_addr = AW'(w_abs_row * IMG_W + w_abs_col);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_org_row <= '0;
          r_org_col <= '0;
          r_pad     <= 1'b0;
        end else begin
          if (w_start_ok) begin
            r_org_row <= i_start_row[gi*RW +: RW];
            r_org_col <= i_start_col[gi*CW +: CW];
          end
          if (w_load) r_pad <= w_pad;
        end
      end

      always_ff @(posedge clk) begin
        if (w_load && !w_pad) r_rd_data <= r_mem[w_rd_addr];
      end

      assign o_out[gi*DATA_WIDTH +: DATA_WIDTH] = (r_valid && !r_pad) ? r_rd_data : '0;
      assign o_out_pad[gi] = r_valid && r_pad;
    end
  endgenerate

  assign o_out_valid = r_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_window_fetch_unit.sv
// Directed bench for window_fetch_unit: ordering, stalls, padding, reset abort,
// illegal kernel sizes, ignored restarts and read-before-write behaviour.
module tb_window_fetch_unit;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int RW = 3;
  localparam int CW = 3;
  localparam int KW = 3;
  localparam int NU = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic           start = 1'b0;
  logic [NU*RW-1:0] start_row = '0;
  logic [NU*CW-1:0] start_col = '0;
  logic [KW-1:0]  kernel_dim = '0;
  logic [NU*DW-1:0] out;
  logic [NU-1:0]  out_pad;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int dones = 0;

  window_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .i_start_row(start_row), .i_start_col(start_col),
    .i_kernel_dim(kernel_dim),
    .o_out(out), .o_out_pad(out_pad), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) xfers++;
    if (done) dones++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic elem(input string tag, input int e0, input bit p0, input int e1, input bit p1);
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".out0"}, 32'(out[DW-1:0]), e0);
    chk({tag, ".pad0"}, 32'(out_pad[0]), 32'(p0));
    chk({tag, ".out1"}, 32'(out[2*DW-1:DW]), e1);
    chk({tag, ".pad1"}, 32'(out_pad[1]), 32'(p1));
  endtask

  task automatic start_fetch(input int k, input int r0, input int c0, input int r1, input int c1);
    kernel_dim = KW'(k);
    start_row  = {RW'(r1), RW'(r0)};
    start_col  = {CW'(c1), CW'(c0)};
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic write_mem(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    step();
    wr_en = 1'b0;
  endtask

  int base;

  initial begin
    // Reset state
    step();
    step();
    chk("rst.out", out, 0);
    chk("rst.pad", 32'(out_pad), 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 64; i++) write_mem(i, i);

    // T1: k=2, full throughput
    base = xfers;
    start_fetch(2, 0, 0, 0, 1);
    chk("t1.busy", 32'(busy), 1);
    chk("t1.novalid", 32'(out_valid), 0);
    step(); elem("t1.e0", 0, 0, 1, 0);
    step(); elem("t1.e1", 1, 0, 2, 0);
    step(); elem("t1.e2", 8, 0, 9, 0);
    chk("t1.nodone", 32'(done), 0);
    step(); elem("t1.e3", 9, 0, 10, 0);
    step();
    chk("t1.done", 32'(done), 1);
    chk("t1.valid_off", 32'(out_valid), 0);
    step();
    chk("t1.done_off", 32'(done), 0);
    chk("t1.idle", 32'(busy), 0);
    chk("t1.xfers", xfers - base, 4);

    // T2: stall for 3 cycles after the 2nd element
    base = xfers;
    start_fetch(2, 0, 0, 0, 1);
    step(); elem("t2.e0", 0, 0, 1, 0);
    step(); elem("t2.e1", 1, 0, 2, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      elem("t2.hold", 1, 0, 2, 0);
      chk("t2.hold_nodone", 32'(done), 0);
    end
    out_ready = 1'b1;
    step(); elem("t2.e2", 8, 0, 9, 0);
    step(); elem("t2.e3", 9, 0, 10, 0);
    step();
    chk("t2.done", 32'(done), 1);
    chk("t2.xfers", xfers - base, 4);
    step();

    // T3: right and bottom edge padding
    start_fetch(2, 0, 7, 7, 7);
    step(); elem("t3.e0", 7, 0, 63, 0);
    step(); elem("t3.e1", 0, 1, 0, 1);
    step(); elem("t3.e2", 15, 0, 0, 1);
    step(); elem("t3.e3", 0, 1, 0, 1);
    step();
    chk("t3.done", 32'(done), 1);
    step();

    // T4: reset abort mid-fetch, then a fresh k=3 fetch
    start_fetch(3, 0, 0, 1, 1);
    step(); elem("t4.e0", 0, 0, 9, 0);
    step(); elem("t4.e1", 1, 0, 10, 0);
    step(); elem("t4.e2", 2, 0, 11, 0);
    base = dones;
    rst_n = 1'b0;
    #1;
    chk("t4.rst_out", out, 0);
    chk("t4.rst_valid", 32'(out_valid), 0);
    chk("t4.rst_busy", 32'(busy), 0);
    step();
    step();
    chk("t4.no_done", dones - base, 0);
    rst_n = 1'b1;
    step();
    chk("t4.no_done2", dones - base, 0);
    start_fetch(3, 0, 0, 1, 1);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        elem("t4.win", r * 8 + c, 0, (1 + r) * 8 + 1 + c, 0);
      end
    end
    step();
    chk("t4.done", 32'(done), 1);
    step();

    // T5: illegal kernel sizes, restart ignored during fetch, k=1
    base = xfers;
    start_fetch(0, 0, 0, 0, 0);
    chk("t5.k0_done", 32'(done), 1);
    chk("t5.k0_valid", 32'(out_valid), 0);
    step();
    chk("t5.k0_idle", 32'(busy), 0);
    chk("t5.k0_valid2", 32'(out_valid), 0);
    start_fetch(5, 0, 0, 0, 0);
    chk("t5.k5_done", 32'(done), 1);
    step();
    chk("t5.k5_xfers", xfers - base, 0);
    start_fetch(2, 0, 0, 0, 1);
    step(); elem("t5.e0", 0, 0, 1, 0);
    start = 1'b1;
    kernel_dim = KW'(1);
    start_row = {RW'(3), RW'(3)};
    start_col = {CW'(3), CW'(3)};
    step(); elem("t5.e1", 1, 0, 2, 0);
    step(); elem("t5.e2", 8, 0, 9, 0);
    start = 1'b0;
    step(); elem("t5.e3", 9, 0, 10, 0);
    step();
    chk("t5.done", 32'(done), 1);
    step();
    chk("t5.idle", 32'(busy), 0);
    start_fetch(1, 3, 4, 7, 7);
    step(); elem("t5.k1", 28, 0, 63, 0);
    step();
    chk("t5.k1_done", 32'(done), 1);
    step();

    // T6: write during fetch, and same-edge read-before-write
    start_fetch(2, 0, 0, 0, 1);
    step(); elem("t6a.e0", 0, 0, 1, 0);
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = DW'(500);
    step(); elem("t6a.e1", 1, 0, 2, 0);
    wr_en = 1'b0;
    step(); elem("t6a.e2", 8, 0, 500, 0);
    step(); elem("t6a.e3", 500, 0, 10, 0);
    step();
    chk("t6a.done", 32'(done), 1);
    step();
    write_mem(9, 9);
    start_fetch(2, 0, 0, 0, 1);
    step(); elem("t6b.e0", 0, 0, 1, 0);
    step(); elem("t6b.e1", 1, 0, 2, 0);
    step(); elem("t6b.e2", 8, 0, 9, 0);
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = DW'(777);
    step(); elem("t6b.e3", 9, 0, 10, 0);
    wr_en = 1'b0;
    step();
    chk("t6b.done", 32'(done), 1);
    step();
    start_fetch(1, 1, 1, 1, 1);
    step(); elem("t6c.new", 777, 0, 777, 0);
    step();
    chk("t6c.done", 32'(done), 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
